fl_binder_arbiter: RTL
======================

// Module: fl_binder_arbiter
// PURPOSE
//  Frame-granular round-robin arbiter that sequences INPUT_COUNT FrameLink sources onto the
//  single FrameLink output of the FL binder. Decides which RX port owns TX and drives the
//  per-port handshake. Drives SEL for the binder's external data/REM/SOP/EOP mux.
//  Once granted, an input keeps TX until its EOF word transfers, so frames never interleave.
// PARAMETERS
//  INPUT_COUNT  4     number of RX FrameLink ports; 2..16; need not be a power of two
//  SEL_WIDTH    2     width of SEL; must equal max(1, clog2(INPUT_COUNT))
//  TIMEOUT      1024  watchdog limit in starved cycles; used only with FL_BINDER_ARB_WATCHDOG_EN
// PORTS
//  CLK           in   1            single clock; all logic on its rising edge
//  RESET         in   1            asynchronous, active-low reset
//  RX_SOF_N      in   INPUT_COUNT  per-port start of frame (active low)
//  RX_EOF_N      in   INPUT_COUNT  per-port end of frame (active low)
//  RX_SRC_RDY_N  in   INPUT_COUNT  per-port source ready (active low)
//  RX_DST_RDY_N  out  INPUT_COUNT  per-port destination ready (active low)
//  TX_DST_RDY_N  in   1            output destination ready (active low)
//  TX_SRC_RDY_N  out  1            output source ready (active low)
//  SEL           out  SEL_WIDTH    index of the granted port; drives the binder data mux
//  BUSY          out  1            1 while in LOCKED
//  TIMEOUT_ERR   out  1            one-cycle watchdog pulse; constant 0 when the macro is undefined
// BEHAVIOUR
//  - Reset values (asynchronous, while RESET=0):
//    FSM=IDLE, PTR=0, SEL=0, BUSY=0, TX_SRC_RDY_N=1, RX_DST_RDY_N=all 1, TIMEOUT_ERR=0, WDOG=0.
//  - Request: req[i] = !RX_SRC_RDY_N[i] & !RX_SOF_N[i].
//    A port showing SRC_RDY without SOF while not granted is held off (DST_RDY_N=1) and ignored.
//  - Transfer: xfer = BUSY & !RX_SRC_RDY_N[SEL] & !TX_DST_RDY_N.
//  - FSM state IDLE:
//    - Outputs idle: TX_SRC_RDY_N=1, RX_DST_RDY_N=all 1.
//    - If any req: winner = first i with req[i] when scanning PTR, PTR+1, ..., wrapping mod INPUT_COUNT.
//    - SEL<=winner; FSM<=LOCKED on the next edge. Grant latency is 1 cycle.
//  - FSM state LOCKED:
//    - TX_SRC_RDY_N = RX_SRC_RDY_N[SEL]; RX_DST_RDY_N[SEL] = TX_DST_RDY_N; all other RX_DST_RDY_N=1.
//    - On xfer with !RX_EOF_N[SEL]: FSM<=IDLE; PTR<=(SEL+1) mod INPUT_COUNT.
//  - Single-word frame: SOF and EOF on the same word releases after that one transfer.
//  - Back-to-back frames: one idle (bubble) cycle between EOF transfer and the next grant.
//  - Wrap-around: PTR=INPUT_COUNT-1 advances to 0. For non-power-of-2 counts, SEL never exceeds INPUT_COUNT-1.
//  - Simultaneous requests: only PTR order decides; requests arriving during LOCKED wait.
//  - Backpressure: TX_DST_RDY_N=1 never changes the owner and never counts toward the watchdog.
//  - Reset mid-frame: immediate return to reset values. The partial frame is the source's concern;
//    arbitration restarts from port 0.
// CONFIGURATION
//  - FL_BINDER_ARB_WATCHDOG_EN defined:
//    - WDOG counter, width clog2(TIMEOUT+1), runs in LOCKED.
//    - Increments when RX_SRC_RDY_N[SEL]=1 and TX_DST_RDY_N=0 (source starved).
//    - Cleared on xfer, on entering LOCKED, and when TX_DST_RDY_N=1.
//    - On reaching TIMEOUT: TIMEOUT_ERR=1 for exactly one cycle; FSM<=IDLE; PTR<=(SEL+1) mod INPUT_COUNT; WDOG<=0.
//  - FL_BINDER_ARB_WATCHDOG_EN undefined:
//    - No counter. TIMEOUT_ERR tied to 0.
//    - A stalled owner holds the lock indefinitely.
// TESTING (INPUT_COUNT=4, TIMEOUT=16, TX_DST_RDY_N=0 unless stated)
//  1. Port 2 alone sends a 3-word frame at t0 -> SEL=2 and BUSY=1 at t0+1, 3 transfers,
//     IDLE the cycle after EOF, PTR=3.
//  2. Ports 0..3 all request at once with 2-word frames -> served in order 0,1,2,3;
//     exactly one bubble cycle between frames; no word interleaving.
//  3. PTR=3 with ports 0 and 3 requesting -> port 3 granted first, then port 0; PTR ends at 1.
//  4. TX_DST_RDY_N=1 for 5 cycles mid-frame -> RX_DST_RDY_N[SEL]=1 during the stall,
//     SEL unchanged, TIMEOUT_ERR=0, frame completes afterwards.
//  5. RESET=0 on the 2nd word of a frame from port 1 -> all outputs at reset values the same cycle;
//     after release, a request on port 1 is granted with PTR starting at 0.
//  6. Macro on: granted port 0 drops SRC_RDY for 16 cycles -> TIMEOUT_ERR single-cycle pulse,
//     FSM IDLE, a pending port 1 granted next.
//     Macro off: same stimulus -> no pulse, SEL=0 held.

Source files
------------

// File: rtl/fl_binder_arbiter.sv
// fl_binder_arbiter
//   Frame-granular round-robin arbiter for the FL binder. Picks which RX
//   FrameLink port owns the single TX port, drives the per-port handshake and
//   exports SEL for the binder's external data/REM/SOP/EOP mux. A granted port
//   keeps TX until its EOF word transfers, so frames never interleave.
//
//   Optional feature macro: FL_BINDER_ARB_WATCHDOG_EN
//     When it is defined, a starvation watchdog releases an owner whose source
//     stays idle for TIMEOUT cycles while TX is ready, and it pulses TIMEOUT_ERR.
//     When it is undefined, TIMEOUT_ERR is tied low and the owner is never forced off.
//
// Parameters
//   INPUT_COUNT  number of RX ports (2..16, any value)
//   SEL_WIDTH    width of SEL, must be max(1, clog2(INPUT_COUNT))
//   TIMEOUT      watchdog limit in starved cycles (watchdog build only)
//
// Ports (all FrameLink strobes are active low)
//   CLK           clock, rising edge
//   RESET         asynchronous active-low reset
//   RX_SOF_N      per-port start of frame
//   RX_EOF_N      per-port end of frame
//   RX_SRC_RDY_N  per-port source ready
//   RX_DST_RDY_N  per-port destination ready (only the owner follows TX)
//   TX_DST_RDY_N  output destination ready
//   TX_SRC_RDY_N  output source ready (owner's source ready)
//   SEL           index of the granted port
//   BUSY          high while a port owns TX
//   TIMEOUT_ERR   one-cycle watchdog pulse
module fl_binder_arbiter #(
    parameter int unsigned INPUT_COUNT = 4,
    parameter int unsigned SEL_WIDTH   = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [INPUT_COUNT-1:0] RX_SOF_N,
    input  logic [INPUT_COUNT-1:0] RX_EOF_N,
    input  logic [INPUT_COUNT-1:0] RX_SRC_RDY_N,
    output logic [INPUT_COUNT-1:0] RX_DST_RDY_N,
    input  logic                   TX_DST_RDY_N,
    output logic                   TX_SRC_RDY_N,
    output logic [SEL_WIDTH-1:0]   SEL,
    output logic                   BUSY,
    output logic                   TIMEOUT_ERR
);

    if (INPUT_COUNT < 2 || INPUT_COUNT > 16 || TIMEOUT < 1 ||
        SEL_WIDTH != ((INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1)) begin : g_param_check
        $error("fl_binder_arbiter: illegal INPUT_COUNT/SEL_WIDTH/TIMEOUT combination");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SEL_WIDTH-1:0]   ptr;
    logic [SEL_WIDTH-1:0]   ptr_nxt;
    logic [SEL_WIDTH-1:0]   sel;
    logic [SEL_WIDTH-1:0]   sel_nxt;
    logic [SEL_WIDTH-1:0]   sel_inc;
    logic [INPUT_COUNT-1:0] req;
    logic                   src_rdy;
    logic                   xfer;
    logic                   found;
    logic                   timeout_hit;
    int unsigned            idx;

    // Only a word carrying SOF can win arbitration; mid-frame words from a
    // non-owner are simply held off.
    assign req     = ~RX_SRC_RDY_N & ~RX_SOF_N;
    assign src_rdy = ~RX_SRC_RDY_N[sel];
    assign xfer    = (state == LOCKED) && src_rdy && !TX_DST_RDY_N;

    // Explicit wrap keeps the pointer inside 0..INPUT_COUNT-1 for counts that
    // are not a power of two.
    assign sel_inc = (sel == SEL_WIDTH'(INPUT_COUNT - 1)) ? '0 : sel + SEL_WIDTH'(1);

`ifdef FL_BINDER_ARB_WATCHDOG_EN
    localparam int unsigned WDOG_WIDTH = $clog2(TIMEOUT + 1);

    logic [WDOG_WIDTH-1:0] wdog;

    assign timeout_hit = (state == LOCKED) && (wdog == WDOG_WIDTH'(TIMEOUT));

    // Counts only cycles where TX could take a word but the owner has none;
    // backpressure and every transfer restart the count.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wdog <= '0;
        end else if (state != LOCKED || timeout_hit || TX_DST_RDY_N || src_rdy) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + WDOG_WIDTH'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign TIMEOUT_ERR = timeout_hit;
    assign BUSY        = (state == LOCKED);
    assign SEL         = sel;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        sel_nxt      = sel;
        TX_SRC_RDY_N = 1'b1;
        RX_DST_RDY_N = '1;
        found        = 1'b0;
        idx          = '0;

        unique case (state)
            IDLE: begin
                // Scan ptr, ptr+1, ... modulo INPUT_COUNT; first requester wins.
                for (int unsigned k = 0; k < INPUT_COUNT; k++) begin
                    idx = 32'(ptr) + k;
                    if (idx >= INPUT_COUNT) begin
                        idx = idx - INPUT_COUNT;
                    end
                    if (!found && req[idx[SEL_WIDTH-1:0]]) begin
                        found   = 1'b1;
                        sel_nxt = idx[SEL_WIDTH-1:0];
                    end
                end
                if (found) begin
                    state_nxt = LOCKED;
                end
            end

            LOCKED: begin
                TX_SRC_RDY_N      = RX_SRC_RDY_N[sel];
                RX_DST_RDY_N[sel] = TX_DST_RDY_N;
                if (timeout_hit || (xfer && !RX_EOF_N[sel])) begin
                    state_nxt = IDLE;
                    ptr_nxt   = sel_inc;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
